// File: rtl/loop_copy_pkg.sv
// Shared types and sizing helpers for the rolled and unrolled wide-word copy blocks.
// Pure compile-time content: no latency, no handshake.
package loop_copy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_W     = 256;
  localparam int DEFAULT_CHUNK = 8;

  function automatic int num_chunks(input int w, input int chunk);
    return w / chunk;
  endfunction

  // A single-chunk word still needs a one-bit index so the counter stays legal.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/loop_rolled_copy_if.sv
// Word-in / word-out handshake bundle for the rolled copy block.
// Carries both valid/ready pairs plus the busy status flag.
interface loop_rolled_copy_if #(
  parameter int W = 256
) ();

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         busy;

  modport master (
    output in_valid, a, out_ready,
    input  in_ready, out_valid, s, busy
  );

  modport slave (
    input  in_valid, a, out_ready,
    output in_ready, out_valid, s, busy
  );

endinterface

// File: rtl/loop_idx_counter.sv
// Modulo-N chunk index counter with synchronous clear, enable and last-chunk flag.
// Advances one step per enabled edge; wraps to 0 after N-1; clear beats enable.
module loop_idx_counter #(
  parameter int N  = 32,
  parameter int IW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [IW-1:0] o_idx,
  output logic          o_last
);

  logic [IW-1:0] r_idx;
  logic          w_last;

  assign w_last = (r_idx == IW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (i_clr) begin
      r_idx <= '0;
    end else if (i_en) begin
      r_idx <= w_last ? '0 : r_idx + IW'(1);
    end
  end

  assign o_idx  = r_idx;
  assign o_last = w_last;

endmodule

// File: rtl/loop_rolled_copy.sv
// Rolled wide-word copy: accepts a word, copies it CHUNK bits per cycle, presents it; out_valid N edges after accept.
// Back-pressure: holds in DONE with s frozen until out_ready; in_ready only while IDLE.
module loop_rolled_copy
  import loop_copy_pkg::*;
#(
  parameter int W     = DEFAULT_W,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic              clk,
  input  logic              rst_n,
  loop_rolled_copy_if.slave io
);

  localparam int N  = num_chunks(W, CHUNK);
  localparam int IW = idx_width(N);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [W-1:0]  r_a_q;
  logic [W-1:0]  r_s;
  logic [IW-1:0] w_idx;
  logic          w_last;
  logic          w_accept;
  logic          w_run;
  logic          w_in_ready;
  logic          w_busy;
  logic          w_out_valid;

  assign w_accept = (r_state == IDLE) && io.in_valid;
  assign w_run    = (r_state == RUN);

  loop_idx_counter #(
    .N  (N),
    .IW (IW)
  ) u_idx (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_accept),
    .i_en   (w_run),
    .o_idx  (w_idx),
    .o_last (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (io.in_valid) w_state_nxt = RUN;
      RUN:     if (w_last)      w_state_nxt = DONE;
      DONE:    if (io.out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_in_ready  = 1'b0;
    w_busy      = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE:    w_in_ready  = 1'b1;
      RUN:     w_busy      = 1'b1;
      DONE:    w_out_valid = 1'b1;
      default: w_in_ready  = 1'b0;
    endcase
  end

  // Chunks above idx keep the previous word until RUN reaches them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_q <= '0;
      r_s   <= '0;
    end else begin
      if (w_accept) begin
        r_a_q <= io.a;
      end
      if (w_run) begin
        for (int k = 0; k < N; k++) begin
          if (w_idx == IW'(k)) begin
            r_s[k*CHUNK +: CHUNK] <= r_a_q[k*CHUNK +: CHUNK];
          end
        end
      end
    end
  end

  assign io.in_ready  = w_in_ready;
  assign io.busy      = w_busy;
  assign io.out_valid = w_out_valid;
  assign io.s         = r_s;

endmodule

// File: tb/tb_loop_rolled_copy.sv
// Self-checking bench for loop_rolled_copy: vector table, scoreboard queue and multi-cycle corner sequences.
module tb_loop_rolled_copy;
  import loop_copy_pkg::*;

  localparam int W  = 256;
  localparam int N8 = W / DEFAULT_CHUNK;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  loop_rolled_copy_if #(.W(W)) if0 ();
  loop_rolled_copy_if #(.W(W)) if1 ();
  loop_rolled_copy_if #(.W(W)) if2 ();

  loop_rolled_copy #(.W(W), .CHUNK(DEFAULT_CHUNK)) u0 (.clk(clk), .rst_n(rst_n), .io(if0));
  loop_rolled_copy #(.W(W), .CHUNK(W))             u1 (.clk(clk), .rst_n(rst_n), .io(if1));
  loop_rolled_copy #(.W(W), .CHUNK(1))             u2 (.clk(clk), .rst_n(rst_n), .io(if2));

  int n_pass  = 0;
  int n_total = 0;
  logic [W-1:0] sb_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] a_after;
    int           hold;
    int           exp_lat;
    int           exp_busy;
  } vec_t;

  vec_t vecs[5];

  task automatic check_w(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  task automatic check_i(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    for (int i = 0; i < W / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic run_word(input string tag, input vec_t v);
    int           t;
    int           lat;
    int           busy_cnt;
    logic [W-1:0] exp;
    t = 0;
    while (!if0.in_ready && t < 100) begin
      step();
      t++;
    end
    check_i({tag, "_in_ready_pre"}, int'(if0.in_ready), 1);
    if0.a         = v.a;
    if0.in_valid  = 1'b1;
    if0.out_ready = (v.hold == 0);
    sb_q.push_back(v.a);
    step();
    if0.in_valid = 1'b0;
    if0.a        = v.a_after;
    lat      = 0;
    busy_cnt = 0;
    while (!if0.out_valid && lat < 200) begin
      if (if0.busy) busy_cnt++;
      step();
      lat++;
    end
    check_i({tag, "_latency"}, lat, v.exp_lat);
    check_i({tag, "_busy_cycles"}, busy_cnt, v.exp_busy);
    if (v.hold > 0) begin
      if0.in_valid = 1'b1;
      for (int c = 0; c < v.hold; c++) begin
        if0.a = rand_word();
        step();
        check_i({tag, "_hold_out_valid"}, int'(if0.out_valid), 1);
        check_i({tag, "_hold_in_ready"}, int'(if0.in_ready), 0);
        check_w({tag, "_hold_s"}, if0.s, sb_q[0]);
      end
      if0.in_valid  = 1'b0;
      if0.out_ready = 1'b1;
    end
    exp = sb_q.pop_front();
    check_w({tag, "_s"}, if0.s, exp);
    step();
    check_i({tag, "_in_ready_post"}, int'(if0.in_ready), 1);
    check_i({tag, "_out_valid_post"}, int'(if0.out_valid), 0);
    if0.out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got time limit reached, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] a5;
    int           lat1;
    int           lat2;
    int           acc;
    int           done;
    int           cyc;

    vecs[0] = '{a: {4{64'h0123456789ABCDEF}}, a_after: {4{64'h0123456789ABCDEF}},
                hold: 0, exp_lat: N8, exp_busy: N8};
    vecs[1] = '{a: {8{32'hDEADBEEF}}, a_after: {W{1'b1}},
                hold: 0, exp_lat: N8, exp_busy: N8};
    vecs[2] = '{a: {32{8'hA5}}, a_after: '0,
                hold: 10, exp_lat: N8, exp_busy: N8};
    vecs[3] = '{a: '0, a_after: {W{1'b1}},
                hold: 3, exp_lat: N8, exp_busy: N8};
    vecs[4] = '{a: {W{1'b1}}, a_after: '0,
                hold: 0, exp_lat: N8, exp_busy: N8};

    if0.in_valid = 1'b0; if0.a = '0; if0.out_ready = 1'b0;
    if1.in_valid = 1'b0; if1.a = '0; if1.out_ready = 1'b0;
    if2.in_valid = 1'b0; if2.a = '0; if2.out_ready = 1'b0;

    #12 rst_n = 1'b1;
    step();
    check_i("reset_in_ready", int'(if0.in_ready), 1);
    check_i("reset_out_valid", int'(if0.out_valid), 0);
    check_i("reset_busy", int'(if0.busy), 0);
    check_w("reset_s", if0.s, '0);
    check_w("reset_s_chunk_w", if1.s, '0);
    check_w("reset_s_chunk_1", if2.s, '0);

    for (int i = 0; i < 5; i++) begin
      run_word($sformatf("vec%0d", i), vecs[i]);
    end

    // Abort in the middle of RUN: reset acts before the next edge.
    if0.a        = {4{64'hFEDCBA9876543210}};
    if0.in_valid = 1'b1;
    step();
    if0.in_valid = 1'b0;
    repeat (15) step();
    check_i("midrun_busy", int'(if0.busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check_w("async_reset_s", if0.s, '0);
    check_i("async_reset_out_valid", int'(if0.out_valid), 0);
    check_i("async_reset_busy", int'(if0.busy), 0);
    #3 rst_n = 1'b1;
    step();
    check_i("post_reset_in_ready", int'(if0.in_ready), 1);
    run_word("after_reset", vecs[0]);

    a5 = rand_word();
    if1.a = a5; if2.a = a5;
    if1.in_valid = 1'b1; if2.in_valid = 1'b1;
    step();
    if1.in_valid = 1'b0; if2.in_valid = 1'b0;
    if1.a = ~a5; if2.a = ~a5;
    lat1 = -1;
    lat2 = -1;
    for (int c = 0; c < 300 && (lat1 < 0 || lat2 < 0); c++) begin
      if (lat1 < 0 && if1.out_valid) lat1 = c;
      if (lat2 < 0 && if2.out_valid) lat2 = c;
      step();
    end
    check_i("chunk_w_latency", lat1, 1);
    check_i("chunk_1_latency", lat2, W);
    check_w("chunk_w_s", if1.s, a5);
    check_w("chunk_1_s", if2.s, a5);
    if1.out_ready = 1'b1; if2.out_ready = 1'b1;
    step();
    check_i("chunk_w_in_ready", int'(if1.in_ready), 1);
    check_i("chunk_1_in_ready", int'(if2.in_ready), 1);
    if1.out_ready = 1'b0; if2.out_ready = 1'b0;

    acc  = 0;
    done = 0;
    cyc  = 0;
    if0.in_valid  = 1'b1;
    if0.a         = rand_word();
    if0.out_ready = 1'($urandom_range(0, 1));
    while (done < 100 && cyc < 20000) begin
      if (if0.in_valid && if0.in_ready) begin
        sb_q.push_back(if0.a);
        acc++;
      end
      if (if0.out_valid && if0.out_ready) begin
        if (sb_q.size() == 0) begin
          n_total++;
          $display("FAIL b2b_extra_output: got unexpected word %h, expected none", if0.s);
        end else begin
          check_w("b2b_s", if0.s, sb_q.pop_front());
        end
        done++;
      end
      step();
      cyc++;
      if0.a         = rand_word();
      if0.in_valid  = (acc < 100);
      if0.out_ready = 1'($urandom_range(0, 1));
    end
    if0.in_valid  = 1'b0;
    if0.out_ready = 1'b0;
    check_i("b2b_accepted", acc, 100);
    check_i("b2b_delivered", done, 100);
    check_i("b2b_queue_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
